// File: rtl/clk_div_pkg.sv
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared defaults and duty-cycle helper for prog_clk_divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package clk_div_pkg;

    localparam int DEF_NBITS = 3;
    localparam int DEF_DIV   = 4;

    // Number of high cycles in a period of n cycles: ceil(n/2).
    function automatic int unsigned ceil_half(input int unsigned n);
        return (n + 32'd1) >> 1;
    endfunction

endpackage : clk_div_pkg

`default_nettype wire

// File: rtl/prog_clk_divider.sv
// ============================================================================
// Module      : prog_clk_divider
// Description : Runtime-programmable integer clock divider with glitch-free
//               ratio changes applied only at period boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_clk_divider
    import clk_div_pkg::*;
#(
    parameter int NBITS       = DEF_NBITS,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [NBITS-1:0] i_div,
    output logic             o_load_ack,
    output logic             o_clk,
    output logic             o_tick,
    output logic [NBITS-1:0] o_phase
);

    localparam logic [NBITS-1:0] c_DEF_DIV = NBITS'(DEFAULT_DIV);
    localparam logic [NBITS-1:0] c_CNT_RST = (DEFAULT_DIV == 0) ? '0 : NBITS'(DEFAULT_DIV - 1);

    localparam logic [0:0] ST_STOP = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [NBITS-1:0] cnt_q,        cnt_d;
    logic [NBITS-1:0] div_act_q,    div_act_d;
    logic [NBITS-1:0] div_pend_q,   div_pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic             clk_q,        clk_d;
    logic             tick_q,       tick_d;
    logic             ack_q,        ack_d;
    logic             primed_q,     primed_d;

    logic [0:0]       w_state;
    logic [NBITS-1:0] w_new_div;
    logic             w_load_applied;
    logic             w_last;
    logic             w_boundary;

    assign w_state        = (div_act_q == '0) ? ST_STOP : ST_RUN;
    assign w_load_applied = i_load | pend_valid_q;
    assign w_new_div      = i_load ? i_div : (pend_valid_q ? div_pend_q : div_act_q);
    assign w_last         = (cnt_q == (div_act_q - NBITS'(1)));
    // A stopped divider treats any load as a period boundary.
    assign w_boundary     = (w_state == ST_RUN) ? w_last : w_load_applied;

    always_comb begin
        cnt_d        = cnt_q;
        div_act_d    = div_act_q;
        div_pend_d   = div_pend_q;
        pend_valid_d = pend_valid_q;
        clk_d        = clk_q;
        tick_d       = 1'b0;
        ack_d        = 1'b0;
        primed_d     = primed_q;

        if (i_load) begin
            div_pend_d   = i_div;
            pend_valid_d = 1'b1;
        end

        if (i_enable) begin
            primed_d = 1'b1;
            if (w_boundary) begin
                div_act_d    = w_new_div;
                cnt_d        = '0;
                tick_d       = (w_new_div != '0);
                clk_d        = (w_new_div != '0);
                ack_d        = w_load_applied;
                pend_valid_d = 1'b0;
            end else if (w_state == ST_RUN) begin
                cnt_d = cnt_q + NBITS'(1);
                clk_d = ((32'(cnt_q) + 32'd1) < ceil_half(32'(div_act_q)));
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q        <= c_CNT_RST;
            div_act_q    <= c_DEF_DIV;
            div_pend_q   <= '0;
            pend_valid_q <= 1'b0;
            clk_q        <= 1'b0;
            tick_q       <= 1'b0;
            ack_q        <= 1'b0;
            primed_q     <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            div_act_q    <= div_act_d;
            div_pend_q   <= div_pend_d;
            pend_valid_q <= pend_valid_d;
            clk_q        <= clk_d;
            tick_q       <= tick_d;
            ack_q        <= ack_d;
            primed_q     <= primed_d;
        end
    end

    // Counter rests at N-1 after reset so the first enabled edge wraps; report phase 0 until then.
    assign o_phase    = primed_q ? cnt_q : '0;
    assign o_clk      = clk_q;
    assign o_tick     = tick_q;
    assign o_load_ack = ack_q;

endmodule : prog_clk_divider

`default_nettype wire

// File: tb/tb_prog_clk_divider.sv
// ============================================================================
// Module      : tb_prog_clk_divider
// Description : Directed-vector scoreboard bench for prog_clk_divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_clk_divider;

    logic       clk;
    logic       rst;
    logic       en;
    logic       ld;
    logic [2:0] div;
    logic       ack;
    logic       dclk;
    logic       tick;
    logic [2:0] phase;

    typedef struct {
        logic       eclk;
        logic       etick;
        logic       eack;
        logic [2:0] eph;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   stim_done = 1'b0;

    prog_clk_divider #(.NBITS(3), .DEFAULT_DIV(4)) u_dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_enable   (en),
        .i_load     (ld),
        .i_div      (div),
        .o_load_ack (ack),
        .o_clk      (dclk),
        .o_tick     (tick),
        .o_phase    (phase)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic v(input logic r, input logic e, input logic l, input logic [2:0] d,
                     input logic xc, input logic xt, input logic [2:0] xp, input logic xa,
                     input string nm);
        exp_t x;
        @(negedge clk);
        rst = r; en = e; ld = l; div = d;
        x.eclk = xc; x.etick = xt; x.eph = xp; x.eack = xa; x.name = nm;
        exp_q.push_back(x);
    endtask

    task automatic cmp(input string nm, input string fld, input logic [2:0] act, input logic [2:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: actual=%0d required=%0d at %0t", nm, fld, act, req, $time);
        end
    endtask

    // Monitor: every edge the DUT presents a new output set; pop and compare.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp(e.name, "clk",   {2'b0, dclk}, {2'b0, e.eclk});
                cmp(e.name, "tick",  {2'b0, tick}, {2'b0, e.etick});
                cmp(e.name, "ack",   {2'b0, ack},  {2'b0, e.eack});
                cmp(e.name, "phase", phase,        e.eph);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: stimulus did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; en = 1'b0; ld = 1'b0; div = 3'd0;
        //  rst en ld div   clk tick ph ack
        v(1, 0, 0, 3'd0,  0, 0, 3'd0, 0, "reset0");
        v(1, 1, 0, 3'd0,  0, 0, 3'd0, 0, "reset1");
        // Default N=4: 1,1,0,0 with tick at each period start
        v(0, 1, 0, 3'd0,  1, 1, 3'd0, 0, "n4_p0");
        v(0, 1, 0, 3'd0,  1, 0, 3'd1, 0, "n4_p1");
        v(0, 1, 0, 3'd0,  0, 0, 3'd2, 0, "n4_p2");
        v(0, 1, 0, 3'd0,  0, 0, 3'd3, 0, "n4_p3");
        v(0, 1, 0, 3'd0,  1, 1, 3'd0, 0, "n4b_p0");
        v(0, 1, 0, 3'd0,  1, 0, 3'd1, 0, "n4b_p1");
        // Load 5 mid-period: current period completes at length 4
        v(0, 1, 1, 3'd5,  0, 0, 3'd2, 0, "ld5_p2");
        v(0, 1, 0, 3'd0,  0, 0, 3'd3, 0, "ld5_p3");
        v(0, 1, 0, 3'd0,  1, 1, 3'd0, 1, "n5_ack");
        v(0, 1, 0, 3'd0,  1, 0, 3'd1, 0, "n5_p1");
        v(0, 1, 0, 3'd0,  1, 0, 3'd2, 0, "n5_p2");
        v(0, 1, 0, 3'd0,  0, 0, 3'd3, 0, "n5_p3");
        v(0, 1, 0, 3'd0,  0, 0, 3'd4, 0, "n5_p4");
        v(0, 1, 0, 3'd0,  1, 1, 3'd0, 0, "n5b_p0");
        v(0, 1, 0, 3'd0,  1, 0, 3'd1, 0, "n5b_p1");
        v(0, 1, 0, 3'd0,  1, 0, 3'd2, 0, "n5b_p2");
        v(0, 1, 0, 3'd0,  0, 0, 3'd3, 0, "n5b_p3");
        v(0, 1, 0, 3'd0,  0, 0, 3'd4, 0, "n5b_p4");
        // Load 2 on the wrap edge itself
        v(0, 1, 1, 3'd2,  1, 1, 3'd0, 1, "n2_ack");
        v(0, 1, 0, 3'd0,  0, 0, 3'd1, 0, "n2_p1");
        v(0, 1, 0, 3'd0,  1, 1, 3'd0, 0, "n2b_p0");
        v(0, 1, 0, 3'd0,  0, 0, 3'd1, 0, "n2b_p1");
        // Load 0 on wrap -> stopped
        v(0, 1, 1, 3'd0,  0, 0, 3'd0, 1, "stop_ack");
        v(0, 1, 0, 3'd0,  0, 0, 3'd0, 0, "stop_a");
        v(0, 1, 0, 3'd0,  0, 0, 3'd0, 0, "stop_b");
        // Load 3 while stopped -> immediate period start
        v(0, 1, 1, 3'd3,  1, 1, 3'd0, 1, "n3_ack");
        v(0, 1, 0, 3'd0,  1, 0, 3'd1, 0, "n3_p1");
        v(0, 1, 0, 3'd0,  0, 0, 3'd2, 0, "n3_p2");
        v(0, 1, 0, 3'd0,  1, 1, 3'd0, 0, "n3b_p0");
        v(0, 1, 0, 3'd0,  1, 0, 3'd1, 0, "n3b_p1");
        v(0, 1, 0, 3'd0,  0, 0, 3'd2, 0, "n3b_p2");
        // Back to N=4, then freeze at phase 2 for three cycles
        v(0, 1, 1, 3'd4,  1, 1, 3'd0, 1, "n4c_ack");
        v(0, 1, 0, 3'd0,  1, 0, 3'd1, 0, "n4c_p1");
        v(0, 1, 0, 3'd0,  0, 0, 3'd2, 0, "n4c_p2");
        v(0, 0, 0, 3'd0,  0, 0, 3'd2, 0, "hold_a");
        v(0, 0, 0, 3'd0,  0, 0, 3'd2, 0, "hold_b");
        v(0, 0, 0, 3'd0,  0, 0, 3'd2, 0, "hold_c");
        v(0, 1, 0, 3'd0,  0, 0, 3'd3, 0, "resume_p3");
        v(0, 1, 0, 3'd0,  1, 1, 3'd0, 0, "n4d_p0");
        // Pending load 2, then reset at phase 3 discards it
        v(0, 1, 1, 3'd2,  1, 0, 3'd1, 0, "pend_p1");
        v(0, 1, 0, 3'd0,  0, 0, 3'd2, 0, "pend_p2");
        v(0, 1, 0, 3'd0,  0, 0, 3'd3, 0, "pend_p3");
        v(1, 1, 0, 3'd0,  0, 0, 3'd0, 0, "rst_mid");
        v(1, 0, 0, 3'd0,  0, 0, 3'd0, 0, "rst_mid2");
        v(0, 1, 0, 3'd0,  1, 1, 3'd0, 0, "post_p0");
        v(0, 1, 0, 3'd0,  1, 0, 3'd1, 0, "post_p1");
        v(0, 1, 0, 3'd0,  0, 0, 3'd2, 0, "post_p2");
        v(0, 1, 0, 3'd0,  0, 0, 3'd3, 0, "post_p3");
        v(0, 1, 0, 3'd0,  1, 1, 3'd0, 0, "post_wrap");
        // N=1: clock stays high, tick every cycle
        v(0, 1, 1, 3'd1,  1, 0, 3'd1, 0, "n1_req");
        v(0, 1, 0, 3'd0,  0, 0, 3'd2, 0, "n1_w2");
        v(0, 1, 0, 3'd0,  0, 0, 3'd3, 0, "n1_w3");
        v(0, 1, 0, 3'd0,  1, 1, 3'd0, 1, "n1_ack");
        v(0, 1, 0, 3'd0,  1, 1, 3'd0, 0, "n1_a");
        v(0, 1, 0, 3'd0,  1, 1, 3'd0, 0, "n1_b");
        @(negedge clk);
        @(negedge clk);
        stim_done = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d entries left required=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_prog_clk_divider

`default_nettype wire
